axis_frame_gen: RTL and testbench
=================================

# axis_frame_gen

Synthesisable, runtime-configurable AXI-Stream master traffic generator, the successor to the fixed-parameter testbench stimulus source. Emits bursts of frames with per-run frame count, frame length, inter-frame gap, last-beat byte mask and data pattern (counter / LFSR / fixed), fully honouring backpressure. Sits ahead of the DMA S2MM path in both simulation and on-chip loopback builds, controlled from a register block or a bench.

## Interface
- DATA_WIDTH, 32, tdata width; multiple of 8, else `$fatal`.
- CNTR_WIDTH, 8, pattern field width in low tdata bits; ≤ DATA_WIDTH and ≤ 32, else `$fatal`.
- LEN_WIDTH, 16, width of cfg_frame_len.
- NUM_WIDTH, 16, width of cfg_num_frames and frames_sent.
- GAP_WIDTH, 8, width of cfg_gap.
- FIXED_DATA, all ones, DATA_WIDTH-CNTR_WIDTH bits, constant upper tdata field.
- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  synchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- stop  in  1  level; end run after the current frame.
- cfg_num_frames  in  NUM_WIDTH  frames per run; 0 = continuous until stop.
- cfg_frame_len  in  LEN_WIDTH  beats per frame; 0 treated as 1.
- cfg_gap  in  GAP_WIDTH  idle cycles between frames.
- cfg_last_keep  in  DATA_WIDTH/8  tkeep on the tlast beat; all other beats all ones.
- cfg_mode  in  2  0 counter, 1 LFSR, 2 fixed (pattern field 0), 3 treated as 0.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of run.
- frames_sent  out  NUM_WIDTH  frames completed in current/last run.
- M_AXIS_tdata  out  DATA_WIDTH  {FIXED_DATA, pattern}.
- M_AXIS_tkeep  out  DATA_WIDTH/8  byte enables.
- M_AXIS_tlast  out  1  last beat of frame.
- M_AXIS_tvalid  out  1  beat valid.
- M_AXIS_tready  in  1  sink ready.

## Operation
- FSM IDLE → SEND → (GAP → SEND)* → IDLE.
- IDLE: start=1 latches all cfg_* inputs, clears frames_sent, zeroes counter, seeds LFSR to 32'h1, enters SEND. cfg_* changes after acceptance are ignored until the next run.
- SEND: tvalid=1. Beat accepted when tvalid&tready; beat counter, pattern and tlast advance only on acceptance. tdata/tkeep/tlast stable while tvalid&!tready.
- Counter mode: pattern = beat index in frame, restarts at 0 each frame, wraps mod 2^CNTR_WIDTH.
- LFSR mode: 32-bit Galois LFSR, poly x^32+x^22+x^2+x+1, advances per accepted beat, NOT reset between frames; pattern = low CNTR_WIDTH bits.
- tlast=1 on beat index frame_len-1; tkeep = cfg_last_keep on that beat.
- On tlast acceptance: frames_sent++; if frames_sent reaches cfg_num_frames (non-zero) or stop=1 → IDLE with done; else cfg_gap=0 → SEND (back-to-back), else GAP.
- GAP: tvalid=0 for exactly cfg_gap cycles, then SEND. stop=1 in GAP → IDLE with done at once.
- start while busy ignored. stop in IDLE ignored.

## Timing
- Reset: tvalid 0, tlast 0, tkeep all ones, tdata {FIXED_DATA, 0}, busy 0, done 0, frames_sent 0, state IDLE.
- start sampled at edge N → tvalid, busy high from edge N+1.
- Final tlast accepted at edge M → tvalid, busy low and done high from edge M+1; done low at M+2; start accepted earliest at M+1.
- Gap G: last handshake at edge M → tvalid low for cycles M+1..M+G, high from M+G+1.
- Frame length 1: every beat carries tlast.
- frames_sent saturates at all ones in continuous mode.
- rstn low mid-frame: outputs return to reset values at the next edge, no frame completion.

## Structure
- Package axis_frame_gen_pkg: mode enum, state enum, LFSR polynomial constant, lfsr_next function.
- Sub-module axis_gen_lfsr (32-bit, load/enable), instantiated once.

## Test plan
- DATA_WIDTH 32, len 4, frames 2, gap 0, counter, tready=1 → 8 beats 0xFFFFFF00..03 twice, tlast on beats 3 and 7, done one cycle after beat 7, frames_sent=2.
- Same with tready toggling 1/0 → identical beat sequence; tdata stable across every stall cycle.
- len 3, gap 5 → exactly 5 idle tvalid cycles between frames.
- cfg_last_keep 4'b0011, len 2 → tkeep 4'hF then 4'h3 with tlast.
- LFSR mode, len 4, frames 2 → beat 0 low byte 0x01, sequence continues across frame boundary without reseed.
- frames 0 (continuous), stop raised mid-frame 3 → frame 3 completes, done pulses, frames_sent=3; start during run ignored.

Source files
------------

// File: rtl/axis_frame_gen_pkg.sv
// Shared types, LFSR constants and the LFSR step function for the
// AXI-Stream frame generator.
package axis_frame_gen_pkg;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_LFSR    = 2'd1,
    MODE_FIXED   = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Taps of x^32 + x^22 + x^2 + x + 1; the x^32 term is the shifted-out bit.
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  function automatic logic [31:0] lfsr_next(input logic [31:0] state);
    return {state[30:0], 1'b0} ^ (state[31] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/axis_gen_lfsr.sv
// 32-bit Galois LFSR with synchronous load and step enable; exposes only
// the low OUT_WIDTH bits used as the data pattern.
module axis_gen_lfsr
  import axis_frame_gen_pkg::*;
#(
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic                 en,
  input  logic [31:0]          seed,
  output logic [OUT_WIDTH-1:0] pattern
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (en) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign pattern = state_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/axis_frame_gen.sv
// Runtime-configurable AXI-Stream master: emits runs of frames with a
// programmable length, gap, last-beat keep and counter/LFSR/fixed pattern.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNTR_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int NUM_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8,
  // Only bits above CNTR_WIDTH reach tdata; the low bits carry the pattern.
  parameter logic [DATA_WIDTH-1:0] FIXED_DATA = '1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [NUM_WIDTH-1:0]    cfg_num_frames,
  input  logic [LEN_WIDTH-1:0]    cfg_frame_len,
  input  logic [GAP_WIDTH-1:0]    cfg_gap,
  input  logic [DATA_WIDTH/8-1:0] cfg_last_keep,
  input  logic [1:0]              cfg_mode,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_WIDTH-1:0]    frames_sent,
  output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
  output logic                    M_AXIS_tlast,
  output logic                    M_AXIS_tvalid,
  input  logic                    M_AXIS_tready
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8) != 0) begin : g_chk_data_width
    $fatal(1, "axis_frame_gen: DATA_WIDTH must be a multiple of 8");
  end
  if ((CNTR_WIDTH > DATA_WIDTH) || (CNTR_WIDTH > 32)) begin : g_chk_cntr_width
    $fatal(1, "axis_frame_gen: CNTR_WIDTH must not exceed DATA_WIDTH or 32");
  end

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [NUM_WIDTH-1:0]   num_q, num_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [KEEP_WIDTH-1:0]  keep_q, keep_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [CNTR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NUM_WIDTH-1:0]   frames_q, frames_d;
  logic                   done_q, done_d;

  logic                   lfsr_load;
  logic                   lfsr_en;
  logic [CNTR_WIDTH-1:0]  lfsr_pattern;
  logic                   accept;
  logic                   beat_last;
  logic [NUM_WIDTH-1:0]   frames_inc;
  logic [CNTR_WIDTH-1:0]  pattern;

  axis_gen_lfsr #(
    .OUT_WIDTH (CNTR_WIDTH)
  ) u_lfsr (
    .clk     (clk),
    .rstn    (rstn),
    .load    (lfsr_load),
    .en      (lfsr_en),
    .seed    (LFSR_SEED),
    .pattern (lfsr_pattern)
  );

  assign accept     = (state_q == ST_SEND) && M_AXIS_tready;
  assign beat_last  = (beat_q == (len_q - LEN_WIDTH'(1)));
  assign frames_inc = (&frames_q) ? frames_q : (frames_q + NUM_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_COUNTER;
      len_q     <= LEN_WIDTH'(1);
      num_q     <= '0;
      gap_q     <= '0;
      keep_q    <= '1;
      beat_q    <= '0;
      cnt_q     <= '0;
      gap_cnt_q <= '0;
      frames_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      num_q     <= num_d;
      gap_q     <= gap_d;
      keep_q    <= keep_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      gap_cnt_q <= gap_cnt_d;
      frames_q  <= frames_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    num_d     = num_q;
    gap_d     = gap_q;
    keep_d    = keep_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    gap_cnt_d = gap_cnt_q;
    frames_d  = frames_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SEND;
          mode_d    = (cfg_mode == MODE_RSVD) ? MODE_COUNTER : mode_e'(cfg_mode);
          len_d     = (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
          num_d     = cfg_num_frames;
          gap_d     = cfg_gap;
          keep_d    = cfg_last_keep;
          beat_d    = '0;
          cnt_d     = '0;
          frames_d  = '0;
          lfsr_load = 1'b1;
        end
      end

      ST_SEND: begin
        if (accept) begin
          lfsr_en = 1'b1;
          if (beat_last) begin
            beat_d   = '0;
            cnt_d    = '0;
            frames_d = frames_inc;
            if (stop || ((num_q != '0) && (frames_inc == num_q))) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
            end
          end else begin
            beat_d = beat_q + LEN_WIDTH'(1);
            cnt_d  = cnt_q + CNTR_WIDTH'(1);
          end
        end
      end

      ST_GAP: begin
        // Counter holds the idle cycles still owed, including the current one.
        if (stop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
          state_d = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    case (mode_q)
      MODE_COUNTER: pattern = cnt_q;
      MODE_LFSR:    pattern = lfsr_pattern;
      default:      pattern = '0;
    endcase

    M_AXIS_tdata                 = FIXED_DATA;
    M_AXIS_tdata[CNTR_WIDTH-1:0] = pattern;
    M_AXIS_tvalid                = (state_q == ST_SEND);
    M_AXIS_tlast                 = (state_q == ST_SEND) && beat_last;
    M_AXIS_tkeep                 = M_AXIS_tlast ? keep_q : {KEEP_WIDTH{1'b1}};
    busy                         = (state_q != ST_IDLE);
  end

  assign done        = done_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Randomized self-checking bench for axis_frame_gen: each run is predicted
// as a list of beats from the configuration and compared beat by beat.
module tb_axis_frame_gen;

   localparam int DW = 32;
   localparam int KW = DW / 8;
   localparam int CW = 8;
   localparam int LW = 16;
   localparam int NW = 16;
   localparam int GW = 8;
   localparam int RUN_BUDGET = 20000;

   typedef struct {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [NW-1:0] cfg_num_frames = '0;
   logic [LW-1:0] cfg_frame_len = '0;
   logic [GW-1:0] cfg_gap = '0;
   logic [KW-1:0] cfg_last_keep = '1;
   logic [1:0]    cfg_mode = '0;
   logic          busy;
   logic          done;
   logic [NW-1:0] frames_sent;
   logic [DW-1:0] tdata;
   logic [KW-1:0] tkeep;
   logic          tlast;
   logic          tvalid;
   logic          tready = 1'b0;

   int    nChecks = 0;
   int    nFails = 0;
   beat_t expQ[$];

   // Free-running 10 ns clock; inputs change and outputs are sampled on negedge.
   always #5 clk = ~clk;

   axis_frame_gen #(
      .DATA_WIDTH (DW),
      .CNTR_WIDTH (CW),
      .LEN_WIDTH  (LW),
      .NUM_WIDTH  (NW),
      .GAP_WIDTH  (GW)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .start          (start),
      .stop           (stop),
      .cfg_num_frames (cfg_num_frames),
      .cfg_frame_len  (cfg_frame_len),
      .cfg_gap        (cfg_gap),
      .cfg_last_keep  (cfg_last_keep),
      .cfg_mode       (cfg_mode),
      .busy           (busy),
      .done           (done),
      .frames_sent    (frames_sent),
      .M_AXIS_tdata   (tdata),
      .M_AXIS_tkeep   (tkeep),
      .M_AXIS_tlast   (tlast),
      .M_AXIS_tvalid  (tvalid),
      .M_AXIS_tready  (tready)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nChecks++;
      if (observed !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One LFSR step as polynomial multiplication by x, reduced modulo the generator.
   function automatic logic [31:0] lfsrStep(input logic [31:0] s);
      logic [32:0] prod;
      prod = {s, 1'b0};
      if (prod[32]) prod = prod ^ 33'h1_0040_0007;
      return prod[31:0];
   endfunction

   // Predicts the whole run as a beat list, then drives it with random backpressure.
   task automatic applyStimulus(input int num, input int len, input int gap, input logic [KW-1:0] keep,
                                input logic [1:0] mode, input int readyPct, input int stopFrame);
      int          effLen;
      int          total;
      int          framesDone;
      int          idleRun;
      int          beatInFrame;
      int          cycles;
      bit          prevLast;
      logic [31:0] lfsr;
      logic [CW-1:0] pat;
      beat_t       b;

      effLen = (len == 0) ? 1 : len;
      total  = (num == 0) ? stopFrame : num;
      expQ.delete();
      lfsr = 32'h1;
      for (int f = 0; f < total; f++) begin
         for (int i = 0; i < effLen; i++) begin
            case (mode)
               2'd1:    pat = lfsr[CW-1:0];
               2'd2:    pat = '0;
               default: pat = CW'(i % (1 << CW));
            endcase
            b.data = {{(DW-CW){1'b1}}, pat};
            b.last = (i == effLen - 1);
            b.keep = b.last ? keep : {KW{1'b1}};
            expQ.push_back(b);
            lfsr = lfsrStep(lfsr);
         end
      end

      @(negedge clk);
      cfg_num_frames = NW'(num);
      cfg_frame_len  = LW'(len);
      cfg_gap        = GW'(gap);
      cfg_last_keep  = keep;
      cfg_mode       = mode;
      start          = 1'b1;
      @(negedge clk);
      start          = 1'b0;
      cfg_num_frames = NW'($urandom);
      cfg_frame_len  = LW'($urandom);
      cfg_gap        = GW'($urandom);
      cfg_last_keep  = KW'($urandom);
      cfg_mode       = 2'($urandom);
      checkOutput("busy_after_start", 64'(busy), 64'(1));

      framesDone  = 0;
      idleRun     = 0;
      prevLast    = 1'b0;
      beatInFrame = 0;
      cycles      = 0;
      while (expQ.size() > 0 && cycles < RUN_BUDGET) begin
         start = 1'b0;
         checkOutput("busy_in_run", 64'(busy), 64'(1));
         checkOutput("frames_sent_in_run", 64'(frames_sent), 64'(framesDone));
         if (!tvalid) begin
            idleRun++;
         end else begin
            if (prevLast) begin
               checkOutput("gap_cycles", 64'(idleRun), 64'(gap));
               prevLast = 1'b0;
            end
            checkOutput("tdata", 64'(tdata), 64'(expQ[0].data));
            checkOutput("tkeep", 64'(tkeep), 64'(expQ[0].keep));
            checkOutput("tlast", 64'(tlast), 64'(expQ[0].last));
         end
         tready = ($urandom_range(99) < readyPct);
         if (tvalid && tready) begin
            b = expQ.pop_front();
            if (stopFrame != 0 && framesDone == stopFrame - 1 && beatInFrame == 0) begin
               stop  = 1'b1;
               start = 1'b1;
            end
            if (b.last) begin
               framesDone++;
               beatInFrame = 0;
               idleRun     = 0;
               prevLast    = 1'b1;
            end else begin
               beatInFrame++;
            end
         end
         @(negedge clk);
         cycles++;
      end

      start = 1'b0;
      checkOutput("run_timeout", 64'(cycles >= RUN_BUDGET), 64'(0));
      checkOutput("done_pulse", 64'(done), 64'(1));
      checkOutput("busy_end", 64'(busy), 64'(0));
      checkOutput("tvalid_end", 64'(tvalid), 64'(0));
      checkOutput("frames_sent_end", 64'(frames_sent), 64'(total));
      stop   = 1'b0;
      tready = 1'b0;
      @(negedge clk);
      checkOutput("done_low", 64'(done), 64'(0));
      checkOutput("idle_after_done", 64'(tvalid), 64'(0));
   endtask

   // Global watchdog so a wedged DUT can never hang the run.
   initial begin
      #900_000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed hang, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset checks, directed runs, random runs, mid-frame reset.
   initial begin
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_tvalid", 64'(tvalid), 64'(0));
      checkOutput("rst_tlast", 64'(tlast), 64'(0));
      checkOutput("rst_tkeep", 64'(tkeep), 64'(4'hF));
      checkOutput("rst_tdata", 64'(tdata), 64'(32'hFFFF_FF00));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_done", 64'(done), 64'(0));
      checkOutput("rst_frames_sent", 64'(frames_sent), 64'(0));
      rstn = 1'b1;
      stop = 1'b1;
      @(negedge clk);
      checkOutput("stop_in_idle", 64'(busy), 64'(0));
      stop = 1'b0;

      applyStimulus(2, 4, 0, 4'hF, 2'd0, 100, 0);
      applyStimulus(2, 4, 0, 4'hF, 2'd0, 50, 0);
      applyStimulus(3, 3, 5, 4'hF, 2'd0, 70, 0);
      applyStimulus(2, 2, 0, 4'b0011, 2'd0, 100, 0);
      applyStimulus(2, 4, 0, 4'hF, 2'd1, 60, 0);
      applyStimulus(0, 5, 2, 4'h7, 2'd1, 80, 3);
      applyStimulus(4, 1, 1, 4'h1, 2'd2, 60, 0);
      applyStimulus(2, 0, 0, 4'h3, 2'd3, 100, 0);
      applyStimulus(1, 260, 0, 4'hF, 2'd0, 90, 0);
      for (int r = 0; r < 6; r++) begin
         applyStimulus($urandom_range(1, 4), $urandom_range(1, 9), $urandom_range(0, 3),
                       KW'($urandom), 2'($urandom), $urandom_range(30, 100), 0);
      end

      @(negedge clk);
      cfg_num_frames = NW'(4);
      cfg_frame_len  = LW'(3);
      cfg_gap        = '0;
      cfg_mode       = 2'd0;
      start          = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      tready = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("pre_reset_frames", 64'(frames_sent), 64'(1));
      rstn = 1'b0;
      @(negedge clk);
      checkOutput("midrst_tvalid", 64'(tvalid), 64'(0));
      checkOutput("midrst_busy", 64'(busy), 64'(0));
      checkOutput("midrst_done", 64'(done), 64'(0));
      checkOutput("midrst_frames_sent", 64'(frames_sent), 64'(0));
      checkOutput("midrst_tdata", 64'(tdata), 64'(32'hFFFF_FF00));
      rstn   = 1'b1;
      tready = 1'b0;
      applyStimulus(1, 3, 0, 4'hF, 2'd1, 100, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
